// File: rtl/dtc_stream_engine.sv
// dtc_stream_engine: decision-tree classifier walking a register node table,
// one node per cycle, producing a thermometer-coded class level.
module dtc_stream_engine #(
  parameter int unsigned IN_W    = 9,
  parameter int unsigned OUT_W   = 9,
  parameter int unsigned NODE_AW = 6,
  parameter int unsigned DEPTH   = 8,
  localparam int unsigned FI_W   = $clog2(IN_W),
  localparam int unsigned LVL_W  = $clog2(OUT_W + 1),
  localparam int unsigned ENT_W  = 1 + FI_W + 2 * NODE_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    inp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   outp,
  output logic               out_err,
  input  logic               cfg_we,
  input  logic [NODE_AW-1:0] cfg_addr,
  input  logic [ENT_W-1:0]   cfg_data,
  output logic               cfg_ready
);

  localparam int unsigned N_ENT  = 2 ** NODE_AW;
  localparam int unsigned STEP_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NODE_AW-1:0]   ptr_q, ptr_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [IN_W-1:0]      inp_q, inp_d;
  logic [OUT_W-1:0]     outp_d;
  logic                 err_d;
  logic                 valid_d;

  logic [ENT_W-1:0]     node_tbl [N_ENT];

  logic [ENT_W-1:0]     ent;
  logic                 is_int;
  logic [FI_W-1:0]      fi;
  logic [NODE_AW-1:0]   one_child;
  logic [NODE_AW-1:0]   zero_child;
  logic [LVL_W-1:0]     lvl;
  logic                 fi_bad;
  logic                 sel_bit;
  logic [OUT_W-1:0]     therm;

  assign in_ready  = (state_q == IDLE);
  assign cfg_ready = (state_q == IDLE);

  // Node table: cleared to level-0 leaves in reset, written only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ENT; i++) begin
        node_tbl[i] <= '0;
      end
    end else if (cfg_we && (state_q == IDLE)) begin
      node_tbl[cfg_addr] <= cfg_data;
    end
  end

  // Decode the entry under the walk pointer
  always_comb begin
    ent        = node_tbl[ptr_q];
    is_int     = ent[ENT_W-1];
    fi         = ent[ENT_W-2 -: FI_W];
    one_child  = ent[2*NODE_AW-1 -: NODE_AW];
    zero_child = ent[NODE_AW-1:0];
    lvl        = ent[LVL_W-1:0];
    fi_bad     = (32'(fi) >= IN_W);
    sel_bit    = fi_bad ? 1'b0 : inp_q[fi];
    for (int unsigned i = 0; i < OUT_W; i++) begin
      therm[i] = (32'(lvl) > i);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    step_d  = step_q;
    inp_d   = inp_q;
    outp_d  = outp;
    err_d   = out_err;
    valid_d = out_valid;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          inp_d   = inp;
          ptr_d   = '0;
          step_d  = '0;
          state_d = WALK;
        end
      end
      WALK: begin
        if (is_int) begin
          // Loop guard and out-of-range feature both abort the walk
          if ((step_q == STEP_W'(DEPTH)) || fi_bad) begin
            outp_d  = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            ptr_d  = sel_bit ? one_child : zero_child;
            step_d = step_q + STEP_W'(1);
          end
        end else begin
          outp_d  = therm;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Result is presented one cycle after the leaf is latched
        if (!out_valid) begin
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      step_q    <= '0;
      inp_q     <= '0;
      outp      <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      step_q    <= step_d;
      inp_q     <= inp_d;
      outp      <= outp_d;
      out_err   <= err_d;
      out_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_dtc_stream_engine.sv
// Directed bench for dtc_stream_engine with an expected-result scoreboard.
module tb_dtc_stream_engine;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  inp;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  outp;
  logic        out_err;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [16:0] cfg_data;
  logic        cfg_ready;

  typedef struct {
    logic [8:0] o;
    logic       e;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  dtc_stream_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp      (outp),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] int_ent(input int fi, input int one, input int zero);
    int_ent = {1'b1, 4'(fi), 6'(one), 6'(zero)};
  endfunction

  function automatic logic [16:0] leaf_ent(input int lvl);
    leaf_ent = 17'(lvl);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [16:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // One transaction: push expectation, drive, await result, compare, optionally stall, then drain
  task automatic send(input string tag, input logic [8:0] v, input logic [8:0] eo, input logic ee,
                      input int lat, input logic do_cfg, input logic [16:0] cd, input int hold);
    exp_t e;
    int   cyc;
    sb.push_back('{eo, ee, lat});
    @(negedge clk);
    check({tag, ":in_ready_pre"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; inp = v;
    if (do_cfg) begin
      cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = cd;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      inp = 9'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ":latency"}, 32'(cyc), 32'(lat));
    if (sb.size() == 0) begin
      e = '{9'h0, 1'b0, 0};
      check({tag, ":sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
    end
    check({tag, ":outp"}, 32'(outp), 32'(e.o));
    check({tag, ":out_err"}, 32'(out_err), 32'(e.e));
    check({tag, ":in_ready_busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; inp = 9'($urandom);
      cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = 17'h1;
      @(posedge clk); #1;
      check({tag, ":hold_outp"}, 32'(outp), 32'(e.o));
      check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, ":hold_cfg_ready"}, 32'(cfg_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":in_ready_post"}, 32'(in_ready), 32'd1);
    check({tag, ":valid_post"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; inp = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    #1;
    check("rst:in_ready", 32'(in_ready), 32'd1);
    check("rst:cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:outp", 32'(outp), 32'd0);
    check("rst:out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty table: root is a level-0 leaf
    send("empty", 9'h1FF, 9'h000, 1'b0, 2, 1'b0, '0, 0);

    // Two-level tree splitting on feature 8
    cfg_write(6'd0, int_ent(8, 2, 1));
    cfg_write(6'd1, leaf_ent(7));
    cfg_write(6'd2, leaf_ent(3));
    send("tree0", 9'h000, 9'b001111111, 1'b0, 3, 1'b0, '0, 0);
    send("tree1", 9'h100, 9'b000000111, 1'b0, 3, 1'b0, '0, 0);

    // Feature index out of range aborts immediately
    cfg_write(6'd0, int_ent(9, 2, 1));
    send("badfi", 9'h0AA, 9'h000, 1'b1, 2, 1'b0, '0, 0);

    // Self-loop trips the depth guard
    cfg_write(6'd0, int_ent(0, 0, 0));
    send("loop", 9'h155, 9'h000, 1'b1, 10, 1'b0, '0, 0);

    // Backpressure in DONE; table must not change from stalled writes
    cfg_write(6'd0, leaf_ent(5));
    send("stall", 9'h011, 9'h01F, 1'b0, 2, 1'b0, '0, 5);
    send("after_stall", 9'h000, 9'h01F, 1'b0, 2, 1'b0, '0, 0);

    // Same-cycle config and accept; saturation and exact-width levels
    send("samecyc", 9'h000, 9'h1FF, 1'b0, 2, 1'b1, leaf_ent(12), 0);
    cfg_write(6'd0, leaf_ent(9));
    send("lvl9", 9'h000, 9'h1FF, 1'b0, 2, 1'b0, '0, 0);
    cfg_write(6'd0, leaf_ent(8));
    send("lvl8", 9'h000, 9'h0FF, 1'b0, 2, 1'b0, '0, 0);

    // Reset one cycle into a walk
    cfg_write(6'd0, int_ent(0, 0, 0));
    @(negedge clk);
    in_valid = 1'b1; inp = 9'h000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst:out_valid", 32'(out_valid), 32'd0);
    check("midrst:outp", 32'(outp), 32'd0);
    check("midrst:in_ready", 32'(in_ready), 32'd1);
    check("midrst:out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("midrst:no_valid", 32'(seen), 32'd0);
    send("midrst:cleared", 9'h1FF, 9'h000, 1'b0, 2, 1'b0, '0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
